// File: rtl/sram_arbiter.sv
// ============================================================================
// Module   : sram_arbiter
// Brief    : Three-port (video / renderer / upload) arbiter for an async SRAM
//            with fixed priority, starvation promotion and registered strobes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        i_master_clk,
    input  logic        i_reset,
    input  logic        i_v_req,
    input  logic [19:0] i_v_addr,
    output logic        o_v_ack,
    output logic        o_v_rvalid,
    output logic [23:0] o_v_rdata,
    input  logic        i_r_req,
    input  logic        i_r_we,
    input  logic [19:0] i_r_addr,
    input  logic [23:0] i_r_wdata,
    output logic        o_r_ack,
    output logic        o_r_rvalid,
    output logic [23:0] o_r_rdata,
    input  logic        i_u_req,
    input  logic [19:0] i_u_addr,
    input  logic [23:0] i_u_wdata,
    output logic        o_u_ack,
    output logic [19:0] o_sram_address,
    output logic [23:0] o_sram_data_out,
    input  logic [23:0] i_sram_data_in,
    output logic        o_sram_data_dir_out,
    output logic        o_sram_cs_n,
    output logic        o_sram_oe_n,
    output logic        o_sram_we_n
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD1  = 3'd1,
        S_RD2  = 3'd2,
        S_WR1  = 3'd3,
        S_WR2  = 3'd4,
        S_TURN = 3'd5
    } state_t;

    localparam logic [1:0] c_PORT_NONE = 2'd0;
    localparam logic [1:0] c_PORT_V    = 2'd1;
    localparam logic [1:0] c_PORT_R    = 2'd2;
    localparam logic [1:0] c_PORT_U    = 2'd3;
    localparam logic [7:0] c_LIMIT     = 8'(STARVE_LIMIT);

    state_t      r_state;
    logic [1:0]  r_owner;
    logic [7:0]  r_r_starve;
    logic [7:0]  r_u_starve;

    logic        w_arb;
    logic        w_r_prom;
    logic        w_u_prom;
    logic [1:0]  w_grant;
    logic        w_grant_wr;
    logic [19:0] w_grant_addr;
    logic [23:0] w_grant_wdata;
    logic [1:0]  w_ack_port;

    always_comb begin
        w_arb         = (r_state == S_IDLE) || (r_state == S_RD2) || (r_state == S_WR2);
        w_r_prom      = (r_r_starve == c_LIMIT);
        w_u_prom      = (r_u_starve == c_LIMIT);
        w_grant       = c_PORT_NONE;
        w_grant_wr    = 1'b0;
        w_grant_addr  = i_v_addr;
        w_grant_wdata = i_r_wdata;
        w_ack_port    = c_PORT_NONE;

        // Promoted ports outrank video; renderer wins a tie between promotions.
        if (w_arb) begin
            if (i_r_req && w_r_prom)      w_grant = c_PORT_R;
            else if (i_u_req && w_u_prom) w_grant = c_PORT_U;
            else if (i_v_req)             w_grant = c_PORT_V;
            else if (i_r_req)             w_grant = c_PORT_R;
            else if (i_u_req)             w_grant = c_PORT_U;
        end

        case (w_grant)
            c_PORT_R: begin
                w_grant_wr    = i_r_we;
                w_grant_addr  = i_r_addr;
                w_grant_wdata = i_r_wdata;
            end
            c_PORT_U: begin
                w_grant_wr    = 1'b1;
                w_grant_addr  = i_u_addr;
                w_grant_wdata = i_u_wdata;
            end
            default: ;
        endcase

        // A read granted out of WR2 is acknowledged only once TURN hands over to RD1.
        if (w_grant != c_PORT_NONE && !(r_state == S_WR2 && !w_grant_wr))
            w_ack_port = w_grant;
        else if (r_state == S_TURN)
            w_ack_port = r_owner;
    end

    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state             <= S_IDLE;
            r_owner             <= c_PORT_NONE;
            r_r_starve          <= 8'd0;
            r_u_starve          <= 8'd0;
            o_v_ack             <= 1'b0;
            o_r_ack             <= 1'b0;
            o_u_ack             <= 1'b0;
            o_v_rvalid          <= 1'b0;
            o_r_rvalid          <= 1'b0;
            o_v_rdata           <= 24'd0;
            o_r_rdata           <= 24'd0;
            o_sram_address      <= 20'd0;
            o_sram_data_out     <= 24'd0;
            o_sram_data_dir_out <= 1'b0;
            o_sram_cs_n         <= 1'b1;
            o_sram_oe_n         <= 1'b1;
            o_sram_we_n         <= 1'b1;
        end else begin
            o_v_ack    <= (w_ack_port == c_PORT_V);
            o_r_ack    <= (w_ack_port == c_PORT_R);
            o_u_ack    <= (w_ack_port == c_PORT_U);
            o_v_rvalid <= 1'b0;
            o_r_rvalid <= 1'b0;

            if (w_arb) begin
                if (w_grant == c_PORT_R)
                    r_r_starve <= 8'd0;
                else if (i_r_req && r_r_starve != c_LIMIT)
                    r_r_starve <= r_r_starve + 8'd1;
                if (w_grant == c_PORT_U)
                    r_u_starve <= 8'd0;
                else if (i_u_req && r_u_starve != c_LIMIT)
                    r_u_starve <= r_u_starve + 8'd1;
            end

            if (r_state == S_RD2) begin
                if (r_owner == c_PORT_V) begin
                    o_v_rvalid <= 1'b1;
                    o_v_rdata  <= i_sram_data_in;
                end else if (r_owner == c_PORT_R) begin
                    o_r_rvalid <= 1'b1;
                    o_r_rdata  <= i_sram_data_in;
                end
            end

            case (r_state)
                S_IDLE, S_RD2, S_WR2: begin
                    if (w_grant != c_PORT_NONE) begin
                        r_owner        <= w_grant;
                        o_sram_address <= w_grant_addr;
                        if (w_grant_wr) begin
                            r_state             <= S_WR1;
                            o_sram_data_out     <= w_grant_wdata;
                            o_sram_cs_n         <= 1'b0;
                            o_sram_oe_n         <= 1'b1;
                            o_sram_we_n         <= 1'b0;
                            o_sram_data_dir_out <= 1'b1;
                        end else if (r_state == S_WR2) begin
                            r_state             <= S_TURN;
                            o_sram_cs_n         <= 1'b1;
                            o_sram_oe_n         <= 1'b1;
                            o_sram_we_n         <= 1'b1;
                            o_sram_data_dir_out <= 1'b0;
                        end else begin
                            r_state             <= S_RD1;
                            o_sram_cs_n         <= 1'b0;
                            o_sram_oe_n         <= 1'b0;
                            o_sram_we_n         <= 1'b1;
                            o_sram_data_dir_out <= 1'b0;
                        end
                    end else begin
                        r_state             <= S_IDLE;
                        o_sram_cs_n         <= 1'b1;
                        o_sram_oe_n         <= 1'b1;
                        o_sram_we_n         <= 1'b1;
                        o_sram_data_dir_out <= 1'b0;
                    end
                end
                S_RD1: begin
                    r_state <= S_RD2;
                end
                S_WR1: begin
                    r_state     <= S_WR2;
                    o_sram_we_n <= 1'b1;
                end
                S_TURN: begin
                    r_state             <= S_RD1;
                    o_sram_cs_n         <= 1'b0;
                    o_sram_oe_n         <= 1'b0;
                    o_sram_we_n         <= 1'b1;
                    o_sram_data_dir_out <= 1'b0;
                end
                default: begin
                    r_state             <= S_IDLE;
                    o_sram_cs_n         <= 1'b1;
                    o_sram_oe_n         <= 1'b1;
                    o_sram_we_n         <= 1'b1;
                    o_sram_data_dir_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// Module   : tb_sram_arbiter
// Brief    : Directed self-checking bench for sram_arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

    logic        clk;
    logic        i_reset;
    logic        i_v_req;
    logic [19:0] i_v_addr;
    logic        o_v_ack;
    logic        o_v_rvalid;
    logic [23:0] o_v_rdata;
    logic        i_r_req;
    logic        i_r_we;
    logic [19:0] i_r_addr;
    logic [23:0] i_r_wdata;
    logic        o_r_ack;
    logic        o_r_rvalid;
    logic [23:0] o_r_rdata;
    logic        i_u_req;
    logic [19:0] i_u_addr;
    logic [23:0] i_u_wdata;
    logic        o_u_ack;
    logic [19:0] o_sram_address;
    logic [23:0] o_sram_data_out;
    logic [23:0] i_sram_data_in;
    logic        o_sram_data_dir_out;
    logic        o_sram_cs_n;
    logic        o_sram_oe_n;
    logic        o_sram_we_n;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int viol     = 0;

    sram_arbiter #(.STARVE_LIMIT(8)) dut (
        .i_master_clk        (clk),
        .i_reset             (i_reset),
        .i_v_req             (i_v_req),
        .i_v_addr            (i_v_addr),
        .o_v_ack             (o_v_ack),
        .o_v_rvalid          (o_v_rvalid),
        .o_v_rdata           (o_v_rdata),
        .i_r_req             (i_r_req),
        .i_r_we              (i_r_we),
        .i_r_addr            (i_r_addr),
        .i_r_wdata           (i_r_wdata),
        .o_r_ack             (o_r_ack),
        .o_r_rvalid          (o_r_rvalid),
        .o_r_rdata           (o_r_rdata),
        .i_u_req             (i_u_req),
        .i_u_addr            (i_u_addr),
        .i_u_wdata           (i_u_wdata),
        .o_u_ack             (o_u_ack),
        .o_sram_address      (o_sram_address),
        .o_sram_data_out     (o_sram_data_out),
        .i_sram_data_in      (i_sram_data_in),
        .o_sram_data_dir_out (o_sram_data_dir_out),
        .o_sram_cs_n         (o_sram_cs_n),
        .o_sram_oe_n         (o_sram_oe_n),
        .o_sram_we_n         (o_sram_we_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bus-contention monitor sampled mid-cycle.
    always @(negedge clk) begin
        if ((!o_sram_oe_n && !o_sram_we_n) || (o_sram_data_dir_out && !o_sram_oe_n))
            viol++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int t0, t_v0, t_r, t_u, t_v2;
        i_reset = 1'b0;
        i_v_req = 1'b0; i_v_addr = '0;
        i_r_req = 1'b0; i_r_we = 1'b0; i_r_addr = '0; i_r_wdata = '0;
        i_u_req = 1'b0; i_u_addr = '0; i_u_wdata = '0;
        i_sram_data_in = '0;

        // Reset values take effect before any clock edge.
        #1 i_reset = 1'b1;
        #1;
        check("rst_cs_n",  {31'd0, o_sram_cs_n}, 1);
        check("rst_oe_n",  {31'd0, o_sram_oe_n}, 1);
        check("rst_we_n",  {31'd0, o_sram_we_n}, 1);
        check("rst_dir",   {31'd0, o_sram_data_dir_out}, 0);
        check("rst_addr",  {12'd0, o_sram_address}, 0);
        check("rst_dout",  {8'd0, o_sram_data_out}, 0);
        check("rst_acks",  {29'd0, o_v_ack, o_r_ack, o_u_ack}, 0);
        check("rst_rvld",  {30'd0, o_v_rvalid, o_r_rvalid}, 0);
        check("rst_vrd",   {8'd0, o_v_rdata}, 0);
        check("rst_rrd",   {8'd0, o_r_rdata}, 0);
        repeat (2) @(posedge clk);
        #4 i_reset = 1'b0;
        tick();

        // Single video read.
        i_v_req = 1'b1; i_v_addr = 20'h00010; i_sram_data_in = 24'hABCDEF;
        tick();
        check("v_ack",     {31'd0, o_v_ack}, 1);
        check("v_rd1_oe",  {31'd0, o_sram_oe_n}, 0);
        check("v_rd1_cs",  {31'd0, o_sram_cs_n}, 0);
        check("v_rd1_dir", {31'd0, o_sram_data_dir_out}, 0);
        check("v_addr",    {12'd0, o_sram_address}, 32'h00010);
        i_v_req = 1'b0;
        tick();
        check("v_rd2_ack", {31'd0, o_v_ack}, 0);
        check("v_rd2_oe",  {31'd0, o_sram_oe_n}, 0);
        check("v_rd2_rv",  {31'd0, o_v_rvalid}, 0);
        tick();
        check("v_rvalid",  {31'd0, o_v_rvalid}, 1);
        check("v_rdata",   {8'd0, o_v_rdata}, 32'hABCDEF);
        check("v_post_oe", {31'd0, o_sram_oe_n}, 1);
        check("v_r_rv",    {31'd0, o_r_rvalid}, 0);
        tick();
        check("v_rv_pulse", {31'd0, o_v_rvalid}, 0);

        // Upload write followed by a video read through TURN.
        i_u_req = 1'b1; i_u_addr = 20'h12345; i_u_wdata = 24'h55AA55;
        tick();
        check("u_ack",     {31'd0, o_u_ack}, 1);
        check("wr1_we",    {31'd0, o_sram_we_n}, 0);
        check("wr1_oe",    {31'd0, o_sram_oe_n}, 1);
        check("wr1_dir",   {31'd0, o_sram_data_dir_out}, 1);
        check("wr1_addr",  {12'd0, o_sram_address}, 32'h12345);
        check("wr1_data",  {8'd0, o_sram_data_out}, 32'h55AA55);
        i_u_req = 1'b0;
        i_v_req = 1'b1; i_v_addr = 20'h00000;
        tick();
        check("wr2_we",    {31'd0, o_sram_we_n}, 1);
        check("wr2_cs",    {31'd0, o_sram_cs_n}, 0);
        check("wr2_dir",   {31'd0, o_sram_data_dir_out}, 1);
        check("wr2_addr",  {12'd0, o_sram_address}, 32'h12345);
        check("wr2_data",  {8'd0, o_sram_data_out}, 32'h55AA55);
        tick();
        check("turn_cs",   {31'd0, o_sram_cs_n}, 1);
        check("turn_dir",  {31'd0, o_sram_data_dir_out}, 0);
        check("turn_oe",   {31'd0, o_sram_oe_n}, 1);
        check("turn_ack",  {31'd0, o_v_ack}, 0);
        tick();
        check("tv_ack",    {31'd0, o_v_ack}, 1);
        check("tv_oe",     {31'd0, o_sram_oe_n}, 0);
        check("tv_addr",   {12'd0, o_sram_address}, 0);
        i_v_req = 1'b0;
        tick();
        i_sram_data_in = 24'h123456;
        tick();
        check("tv_rvalid", {31'd0, o_v_rvalid}, 1);
        check("tv_rdata",  {8'd0, o_v_rdata}, 32'h123456);

        // Renderer write stream of four back-to-back requests.
        i_r_req = 1'b1; i_r_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_r_addr  = 20'h00100 + 20'(i);
            i_r_wdata = 24'hC0FFE0 + 24'(i);
            tick();
            check("rw_ack",  {31'd0, o_r_ack}, 1);
            check("rw_data", {8'd0, o_sram_data_out}, 32'hC0FFE0 + i);
            check("rw_cs1",  {31'd0, o_sram_cs_n}, 0);
            if (i == 3) i_r_req = 1'b0;
            tick();
            check("rw_noack", {31'd0, o_r_ack}, 0);
            check("rw_cs2",   {31'd0, o_sram_cs_n}, 0);
        end
        tick();
        check("rw_end_cs", {31'd0, o_sram_cs_n}, 1);

        // Starvation: video held, renderer read and upload write wait for promotion.
        i_r_we = 1'b0; i_r_addr = 20'h00200;
        i_u_addr = 20'h00300; i_u_wdata = 24'h777777;
        i_v_req = 1'b1; i_r_req = 1'b1; i_u_req = 1'b1;
        t0 = cyc; t_v0 = -1; t_r = -1; t_u = -1; t_v2 = -1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (o_v_ack && t_v0 < 0) t_v0 = cyc;
            if (o_r_ack) begin
                if (t_r < 0) t_r = cyc;
                i_r_req = 1'b0;
            end
            if (o_u_ack) begin
                if (t_u < 0) t_u = cyc;
                i_u_req = 1'b0;
            end
            if (o_v_ack && t_u >= 0 && t_v2 < 0) t_v2 = cyc;
        end
        i_v_req = 1'b0; i_r_req = 1'b0; i_u_req = 1'b0;
        check("st_v_first", t_v0 - t0, 1);
        check("st_r_grant", t_r - t_v0, 16);
        check("st_u_grant", t_u - t_v0, 18);
        check("st_v_after", t_v2 - t_v0, 21);
        repeat (6) tick();

        // Reset pulse during RD2 aborts the read.
        i_v_req = 1'b1; i_v_addr = 20'h00042; i_sram_data_in = 24'hDEAD01;
        tick();
        check("ab_ack", {31'd0, o_v_ack}, 1);
        i_v_req = 1'b0;
        tick();
        check("ab_rd2_oe", {31'd0, o_sram_oe_n}, 0);
        i_reset = 1'b1;
        #1;
        check("ab_cs",   {31'd0, o_sram_cs_n}, 1);
        check("ab_oe",   {31'd0, o_sram_oe_n}, 1);
        check("ab_we",   {31'd0, o_sram_we_n}, 1);
        check("ab_dir",  {31'd0, o_sram_data_dir_out}, 0);
        check("ab_addr", {12'd0, o_sram_address}, 0);
        tick();
        check("ab_rv1", {31'd0, o_v_rvalid}, 0);
        #3 i_reset = 1'b0;
        tick();
        check("ab_rv2", {31'd0, o_v_rvalid}, 0);
        check("ab_idle_cs", {31'd0, o_sram_cs_n}, 1);
        i_v_req = 1'b1; i_v_addr = 20'h00077; i_sram_data_in = 24'h0F0F0F;
        tick();
        check("re_ack",  {31'd0, o_v_ack}, 1);
        check("re_addr", {12'd0, o_sram_address}, 32'h00077);
        i_v_req = 1'b0;
        tick();
        tick();
        check("re_rvalid", {31'd0, o_v_rvalid}, 1);
        check("re_rdata",  {8'd0, o_v_rdata}, 32'h0F0F0F);
        tick();

        check("bus_safety", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
